writeback_port_arbiter: RTL and testbench
=========================================

# writeback_port_arbiter

Shares the single register-file write port between the in-order writeback stage and the long-latency multiply/divide unit. Pipeline writeback has priority. Multiply/divide results queue in a small result buffer and drain into idle port cycles. A starvation counter requests a one-cycle writeback stall so queued results are never held forever. The block sits between `writeback_cycle`, the MD unit and the register file, and exports a pending-destination mask to the hazard unit.

## Interface
Parameters:
- `DEPTH`, 2: result-buffer entries; power of two, ≥2.
- `STARVE_LIMIT`, 4: consecutive lost arbitration cycles before a stall is requested; ≥1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `RegWriteW`  in  1: writeback stage writes the register file this cycle.
- `RdW`  in  5: writeback destination.
- `ResultW`  in  32: writeback data.
- `md_valid`  in  1: MD unit presents a result.
- `md_rd`  in  5: MD destination.
- `md_result`  in  32: MD data.
- `md_ready`  out  1: buffer accepts an MD result.
- `stall_wb`  out  1: freeze the writeback stage this cycle.
- `RegWriteRF`  out  1: register-file write enable.
- `RdRF`  out  5: register-file write address.
- `WriteDataRF`  out  32: register-file write data.
- `pending_mask`  out  32: bit r is set when register r has a live buffered result.
- `buf_count`  out  $clog2(DEPTH)+1: occupied entries.

## Operation
- **Push:** an MD result is accepted when `md_valid && md_ready`. It is written at the tail with `live = (md_rd != 0)`. A result for x0 is accepted and discarded.
- **Pipeline request:** `pw = RegWriteW && RdW != 0 && !stall_wb`.
- **Port grant (combinational):**
  - If `pw`, the port drives `RdW`/`ResultW`.
  - Otherwise, if the head is live, the port drives the head entry and the head pops.
  - Otherwise `RegWriteRF = 0`.
- **Dead head:** a non-live head pops in any cycle without using the port.
- **Kill:** when `pw` targets register R, every buffered entry with rd R has `live` cleared on that edge. The buffered value is older and is now stale. An entry pushed in the same cycle is not killed.
- **Starvation counter:**
  - Increments in each cycle where the head is live and `pw` wins the port.
  - Clears on any pop or when the buffer is empty.
  - When the next value would reach `STARVE_LIMIT`, `stall_wb` is registered high for exactly one cycle and the counter clears.
  - During the stall cycle `RegWriteW` is ignored. The stage holds its contents and retries the next cycle.
- `pending_mask` is the OR of one-hot(rd) over live entries, derived from registered state.

## Timing
- **Reset values:** buffer empty, all `live` bits 0, counter 0. Outputs: `stall_wb` 0, `md_ready` 1, `pending_mask` 0, `buf_count` 0. `RegWriteRF` follows the inputs: it is 0 when `RegWriteW` is 0.
- **Reset mid-operation:** discards all queued results immediately. There is no write-back of queued data.
- `md_ready = buf_count < DEPTH` from registered state. There is no same-cycle pop bypass, so a full buffer deasserts ready even while popping.
- **Latency:** a result accepted at edge N can reach the register file at the earliest in the cycle after N (edge N+1 commits it). There is no push-to-port bypass.
- **Push and pop in one cycle:** count is unchanged and pointers wrap modulo `DEPTH`.
- **Empty buffer:** no pop and no counter increment.
- `stall_wb` is asserted at most one cycle in every `STARVE_LIMIT+1`.

## Structure
- **Shared package `wb_pkg`:** `XLEN = 32`, `REG_ADDR_W = 5`, and the struct `wb_entry_t {live, rd, data}`.
- **Sub-module `wb_result_fifo`:** holds the entry storage, pointers, count, kill-by-rd and the mask generator.
- The top level holds the grant mux and the starvation counter.

## Test plan
- **Idle pipeline:** push MD (rd=5, 0xDEAD0001) at edge N → `RegWriteRF = 1`, `RdRF = 5`, `WriteDataRF = 0xDEAD0001` in cycle N+1. `pending_mask` bit 5 is set for one cycle, then clears.
- **Fill:** two MD pushes while `RegWriteW = 1` every cycle (rd=1..) → `md_ready = 0` at count 2. `stall_wb` pulses one cycle after 4 lost cycles. The head (first MD result) is written in that stall cycle.
- **Kill:** MD (rd=7, 0x11) buffered, then pipeline writes rd=7, 0x22 → the register file sees only the 0x22 write. Bit 7 clears, and the dead head pops the next cycle with no register-file write.
- **x0 filter:** MD rd=0 → accepted, `RegWriteRF` never asserted for it, `pending_mask` stays 0. Pipeline `RdW = 0` with `RegWriteW = 1` → the port is given to the buffer head.
- **Simultaneous push and pop:** with DEPTH=2, alternate pushes and pops for 8 cycles → count stays 1. Data emerges in push order across pointer wrap.
- **Reset mid-operation:** `rst` low with 2 entries buffered and the counter at 3 → count 0, mask 0, `stall_wb` 0, `md_ready` 1 immediately, with no register-file writes afterwards.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback port arbiter.
//   XLEN       : register data width
//   REG_ADDR_W : register address width
//   wb_entry_t : one buffered multiply/divide result {live, rd, data}
package wb_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Result buffer for multiply/divide writebacks.
//   clk, rst     : clock, asynchronous active-low reset
//   i_push       : write {live = rd != 0, rd, data} at the tail
//   i_pop        : retire the head entry
//   i_kill       : clear live on every entry whose rd matches i_kill_rd
//   o_head       : head entry (registered state)
//   o_count      : occupied entries
//   o_mask       : one-hot(rd) OR-ed over live entries
// The caller never pushes when full and never pops when empty.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [REG_ADDR_W-1:0] i_push_rd,
    input  logic [XLEN-1:0]       i_push_data,
    input  logic                  i_pop,
    input  logic                  i_kill,
    input  logic [REG_ADDR_W-1:0] i_kill_rd,
    output wb_entry_t             o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [XLEN-1:0]       o_mask
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t              r_mem [DEPTH];
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [XLEN-1:0]        w_mask;

    // Unoccupied slots always hold live = 0, so the mask can scan every slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_kill && (r_mem[i].rd == i_kill_rd)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            if (i_pop) begin
                r_mem[r_rd_ptr].live <= 1'b0;
            end
            // Tail slot is free, so a same-cycle kill never touches the new entry.
            if (i_push) begin
                r_mem[r_wr_ptr].live <= (i_push_rd != '0);
                r_mem[r_wr_ptr].rd   <= i_push_rd;
                r_mem[r_wr_ptr].data <= i_push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].live) begin
                w_mask[r_mem[i].rd] = 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_mask  = w_mask;

endmodule

// File: rtl/writeback_port_arbiter.sv
// Shares the register-file write port between the writeback stage and the
// multiply/divide unit. Pipeline writes win; MD results wait in a buffer and
// drain into idle port cycles; a starvation counter forces a one-cycle stall.
//   clk, rst                  : clock, asynchronous active-low reset
//   RegWriteW/RdW/ResultW     : writeback-stage write request
//   md_valid/md_rd/md_result  : MD result offer; md_ready accepts it
//   stall_wb                  : freeze the writeback stage this cycle
//   RegWriteRF/RdRF/WriteDataRF : register-file write port
//   pending_mask              : registers with a live buffered result
//   buf_count                 : occupied buffer entries
module writeback_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RegWriteW,
    input  logic [REG_ADDR_W-1:0]  RdW,
    input  logic [XLEN-1:0]        ResultW,
    input  logic                   md_valid,
    input  logic [REG_ADDR_W-1:0]  md_rd,
    input  logic [XLEN-1:0]        md_result,
    output logic                   md_ready,
    output logic                   stall_wb,
    output logic                   RegWriteRF,
    output logic [REG_ADDR_W-1:0]  RdRF,
    output logic [XLEN-1:0]        WriteDataRF,
    output logic [XLEN-1:0]        pending_mask,
    output logic [$clog2(DEPTH):0] buf_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1);

    wb_entry_t        w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_empty;
    logic             w_pw;
    logic             w_head_live;
    logic             w_pop;
    logic             w_push;
    logic             w_lost;
    logic [SW-1:0]    r_starve;
    logic [SW-1:0]    w_starve_d;
    logic             r_stall;
    logic             w_stall_d;

    assign w_empty     = (w_count == '0);
    // RegWriteW is ignored while the stage is frozen.
    assign w_pw        = RegWriteW && (RdW != '0) && !r_stall;
    assign w_head_live = !w_empty && w_head.live;
    // A dead head retires without the port; a live one only when the pipeline is idle.
    assign w_pop       = !w_empty && (!w_head.live || !w_pw);
    assign w_lost      = w_head_live && w_pw;
    assign md_ready    = (w_count < CNT_W'(DEPTH));
    assign w_push      = md_valid && md_ready;

    wb_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_rd   (md_rd),
        .i_push_data (md_result),
        .i_pop       (w_pop),
        .i_kill      (w_pw),
        .i_kill_rd   (RdW),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_mask      (pending_mask)
    );

    always_comb begin
        RegWriteRF  = w_pw || w_head_live;
        RdRF        = w_pw ? RdW : w_head.rd;
        WriteDataRF = w_pw ? ResultW : w_head.data;
    end

    always_comb begin
        w_starve_d = r_starve;
        w_stall_d  = 1'b0;
        if (w_empty || w_pop) begin
            w_starve_d = '0;
        end else if (w_lost) begin
            if (r_starve == SW'(STARVE_LIMIT - 1)) begin
                w_starve_d = '0;
                w_stall_d  = 1'b1;
            end else begin
                w_starve_d = r_starve + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_starve <= w_starve_d;
            r_stall  <= w_stall_d;
        end
    end

    assign stall_wb  = r_stall;
    assign buf_count = w_count;

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// Self-checking bench for writeback_port_arbiter: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_writeback_port_arbiter;

    localparam int unsigned DEPTH        = 2;
    localparam int unsigned STARVE_LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_result;
    logic        md_ready;
    logic        stall_wb;
    logic        RegWriteRF;
    logic [4:0]  RdRF;
    logic [31:0] WriteDataRF;
    logic [31:0] pending_mask;
    logic [1:0]  buf_count;

    writeback_port_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .RegWriteW    (RegWriteW),
        .RdW          (RdW),
        .ResultW      (ResultW),
        .md_valid     (md_valid),
        .md_rd        (md_rd),
        .md_result    (md_result),
        .md_ready     (md_ready),
        .stall_wb     (stall_wb),
        .RegWriteRF   (RegWriteRF),
        .RdRF         (RdRF),
        .WriteDataRF  (WriteDataRF),
        .pending_mask (pending_mask),
        .buf_count    (buf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          live;
        logic [4:0]  rd;
        logic [31:0] data;
    } m_entry_t;

    m_entry_t q[$];
    int       m_lost_run;
    bit       m_stall;
    int       vectors;
    int       miscompares;
    int       cyc;
    int       last_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_lost_run = 0;
        m_stall    = 1'b0;
    endtask

    // Apply one cycle of inputs and compare every output with the model.
    task automatic drive(input logic rw, input logic [4:0] rdw, input logic [31:0] resw,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mres);
        logic [31:0] exp_mask;
        bit          hl;
        bit          pw;
        bit          we;
        RegWriteW = rw;
        RdW       = rdw;
        ResultW   = resw;
        md_valid  = mv;
        md_rd     = mrd;
        md_result = mres;
        #2;
        exp_mask = '0;
        foreach (q[i]) if (q[i].live) exp_mask[q[i].rd] = 1'b1;
        hl = (q.size() > 0) && q[0].live;
        pw = rw && (rdw != 5'd0) && !m_stall;
        we = pw || hl;
        check("stall_wb", {31'd0, stall_wb}, {31'd0, m_stall});
        check("md_ready", {31'd0, md_ready}, {31'd0, q.size() < DEPTH});
        check("buf_count", {30'd0, buf_count}, q.size());
        check("pending_mask", pending_mask, exp_mask);
        check("RegWriteRF", {31'd0, RegWriteRF}, {31'd0, we});
        if (we) begin
            check("RdRF", {27'd0, RdRF}, {27'd0, pw ? rdw : q[0].rd});
            check("WriteDataRF", WriteDataRF, pw ? resw : q[0].data);
        end
        if (stall_wb === 1'b1) begin
            check("stall_gap", {31'd0, (cyc - last_stall) >= (STARVE_LIMIT + 1)}, 32'd1);
            last_stall = cyc;
        end
    endtask

    // Advance the model by the current inputs, then cross the clock edge.
    task automatic tick();
        bit       hl;
        bit       pw;
        bit       pop;
        bit       push;
        bit       empty;
        m_entry_t e;
        if (!rst) begin
            model_clear();
        end else begin
            empty = (q.size() == 0);
            hl    = !empty && q[0].live;
            pw    = RegWriteW && (RdW != 5'd0) && !m_stall;
            pop   = !empty && !(hl && pw);
            push  = md_valid && (q.size() < DEPTH);
            // Starvation: count consecutive cycles a live head loses to the pipeline.
            if (empty || pop) begin
                m_lost_run = 0;
                m_stall    = 1'b0;
            end else if (hl && pw) begin
                m_lost_run++;
                m_stall = (m_lost_run == STARVE_LIMIT);
                if (m_stall) m_lost_run = 0;
            end else begin
                m_stall = 1'b0;
            end
            if (pw) begin
                foreach (q[i]) begin
                    if (q[i].rd == RdW) begin
                        e      = q[i];
                        e.live = 1'b0;
                        q[i]   = e;
                    end
                end
            end
            if (pop) void'(q.pop_front());
            if (push) begin
                e.live = (md_rd != 5'd0);
                e.rd   = md_rd;
                e.data = md_result;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            tick();
        end
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        rst = 1'b0;
        model_clear();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        last_stall  = -100;
        model_clear();
        rst       = 1'b0;
        RegWriteW = 1'b0;
        RdW       = '0;
        ResultW   = '0;
        md_valid  = 1'b0;
        md_rd     = '0;
        md_result = '0;
        #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // Idle pipeline: MD result reaches the port the cycle after acceptance.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_0001);
        check("idle_no_bypass", {31'd0, RegWriteRF}, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("idle_we", {31'd0, RegWriteRF}, 32'd1);
        check("idle_rd", {27'd0, RdRF}, 32'd5);
        check("idle_data", WriteDataRF, 32'hDEAD_0001);
        check("idle_mask", pending_mask, 32'h0000_0020);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("idle_mask_clr", pending_mask, 32'd0);
        tick();
        idle(2);

        // Fill under continuous pipeline writes; starvation forces a stall.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'(10 + i), 32'h100 + i, (i < 2), 5'(i + 1), 32'hA000 + i);
            if (i == 2) check("fill_ready", {31'd0, md_ready}, 32'd0);
            if (i == 4) check("fill_no_stall", {31'd0, stall_wb}, 32'd0);
            if (i == 5) begin
                check("fill_stall", {31'd0, stall_wb}, 32'd1);
                check("fill_head_rd", {27'd0, RdRF}, 32'd1);
                check("fill_head_data", WriteDataRF, 32'hA000);
            end
            tick();
        end
        idle(4);

        // Kill: pipeline overwrites a buffered destination.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
        tick();
        drive(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0);
        check("kill_data", WriteDataRF, 32'h22);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("kill_dead_we", {31'd0, RegWriteRF}, 32'd0);
        check("kill_mask", pending_mask, 32'd0);
        check("kill_dead_cnt", {30'd0, buf_count}, 32'd1);
        tick();
        idle(2);

        // x0 filter on both sources.
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hBAD);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("x0_we", {31'd0, RegWriteRF}, 32'd0);
        check("x0_mask", pending_mask, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
        tick();
        drive(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0);
        check("x0_pipe_rd", {27'd0, RdRF}, 32'd3);
        check("x0_pipe_data", WriteDataRF, 32'h33);
        tick();
        idle(2);

        // Simultaneous push and pop across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(8 + i), 32'h200 + i);
            if (i > 0) check("pp_count", {30'd0, buf_count}, 32'd1);
            tick();
        end
        idle(3);

        // Reset with two entries queued and the starvation counter at 3.
        drive(1'b1, 5'd20, 32'h1, 1'b1, 5'd1, 32'hB1);
        tick();
        drive(1'b1, 5'd21, 32'h2, 1'b1, 5'd2, 32'hB2);
        tick();
        drive(1'b1, 5'd22, 32'h3, 1'b0, 5'd0, 32'd0);
        tick();
        drive(1'b1, 5'd23, 32'h4, 1'b0, 5'd0, 32'd0);
        tick();
        check("pre_rst_cnt", {30'd0, buf_count}, 32'd2);
        do_reset();
        idle(3);

        // Random traffic, narrow register range to provoke kills and x0 cases.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                      $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
